ads8684_spi_ctrl: RTL and testbench

ADS8684_SPI_CTRL -- requirements
Module: ads8684_spi_ctrl

---
 rtl/ads8684_spi_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ads8684_spi_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads8684_spi_ctrl.sv
// ADS8684 SPI frame controller: 32-sclk frames, result of frame N-1's channel returned in frame N.
// Optional continuous channel scan: define ADS8684_SPI_CTRL_AUTOSCAN_EN.
module ads8684_spi_ctrl #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  channel,
    input  logic        auto_en,
    output logic        ready,
    output logic [15:0] data,
    output logic [1:0]  data_ch,
    output logic        data_valid,
    output logic        csn,
    output logic        sclk,
    output logic        sdi,
    input  logic        sdo,
    output logic [2:0]  fsm_state
);

    // Handshake: a frame is accepted on any cycle with ready=1 and start=1 (or autoscan);
    // ready is high only in IDLE and a start seen while ready=0 is dropped, never queued.
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t      state;
    logic [7:0]  div_cnt;
    logic [5:0]  edge_cnt;
    logic [7:0]  gap_cnt;
    logic [31:0] tx_sr;
    logic [31:0] rx_sr;
    logic [1:0]  cur_ch;
    logic [1:0]  prev_ch;
    logic        prev_flag;
    logic        launch;
    logic [1:0]  launch_ch;
    logic [31:0] frame_word;

`ifdef ADS8684_SPI_CTRL_AUTOSCAN_EN
    logic        auto_q;
    logic [1:0]  scan_ch;
    logic        scan_rise;
    logic [1:0]  scan_sel;

    always_comb begin
        scan_rise = auto_en && !auto_q;
        scan_sel  = scan_rise ? 2'd0 : scan_ch;
        launch    = ready && (auto_en || start);
        launch_ch = auto_en ? scan_sel : channel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            auto_q  <= 1'b0;
            scan_ch <= 2'd0;
        end else begin
            auto_q <= auto_en;
            if (launch && auto_en)
                scan_ch <= scan_sel + 2'd1;
            else if (scan_rise)
                scan_ch <= 2'd0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{rx_sr[31:16], tx_sr[31]};
`else
    always_comb begin
        launch    = ready && start;
        launch_ch = channel;
    end

    logic unused_bits;
    assign unused_bits = ^{rx_sr[31:16], tx_sr[31], auto_en};
`endif

    assign frame_word = {4'hC, launch_ch, 26'd0};
    assign fsm_state  = state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            ready      <= 1'b0;
            csn        <= 1'b1;
            sclk       <= 1'b0;
            sdi        <= 1'b0;
            data       <= 16'h0000;
            data_ch    <= 2'd0;
            data_valid <= 1'b0;
            prev_flag  <= 1'b0;
            prev_ch    <= 2'd0;
            cur_ch     <= 2'd0;
            div_cnt    <= 8'd0;
            edge_cnt   <= 6'd0;
            gap_cnt    <= 8'd0;
            tx_sr      <= 32'd0;
            rx_sr      <= 32'd0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    ready <= 1'b1;
                    if (launch) begin
                        state  <= SETUP;
                        ready  <= 1'b0;
                        csn    <= 1'b0;
                        cur_ch <= launch_ch;
                        tx_sr  <= frame_word;
                        sdi    <= frame_word[31];
                    end
                end
                SETUP: begin
                    state    <= SHIFT;
                    div_cnt  <= 8'd0;
                    edge_cnt <= 6'd0;
                end
                SHIFT: begin
                    // 64 toggles per frame; the last one is the falling edge that ends SHIFT
                    if (div_cnt == 8'(CLK_DIV - 1)) begin
                        div_cnt  <= 8'd0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 6'd1;
                        if (!sclk) begin
                            rx_sr <= {rx_sr[30:0], sdo};
                        end else begin
                            tx_sr <= {tx_sr[30:0], 1'b0};
                            sdi   <= tx_sr[30];
                        end
                        if (edge_cnt == 6'd63)
                            state <= HOLD;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    state   <= GAP;
                    csn     <= 1'b1;
                    sdi     <= 1'b0;
                    gap_cnt <= 8'd0;
                    // this frame's shift register holds the conversion commanded one frame earlier
                    if (prev_flag) begin
                        data_valid <= 1'b1;
                        data       <= rx_sr[15:0];
                        data_ch    <= prev_ch;
                    end
                    prev_flag <= 1'b1;
                    prev_ch   <= cur_ch;
                end
                GAP: begin
                    if (gap_cnt == 8'(CS_GAP - 1)) begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b0;
                    csn   <= 1'b1;
                    sclk  <= 1'b0;
                    sdi   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ads8684_spi_ctrl.sv
// Bench for ads8684_spi_ctrl: timeline model of frames plus a behavioural ADS8684 on the SPI pins.
module tb_ads8684_spi_ctrl;

    localparam int D         = 2;
    localparam int G         = 4;
    localparam int SHIFT_LEN = 64 * D;
    localparam int LEN       = SHIFT_LEN + 2 + G;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        sdo = 1'b0;
    logic [1:0]  channel = 2'd0;
    logic        ready, data_valid, csn, sclk, sdi;
    logic [15:0] data;
    logic [1:0]  data_ch;
    logic [2:0]  fsm_state;

    logic        start1 = 1'b0;
    logic        zero = 1'b0;
    logic [1:0]  ch1 = 2'd3;
    logic        ready1, dv1, csn1, sclk1, sdi1;
    logic [15:0] data1;
    logic [1:0]  data_ch1;
    logic [2:0]  fsm_state1;

    ads8684_spi_ctrl #(.CLK_DIV(D), .CS_GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .channel(channel), .auto_en(auto_en),
        .ready(ready), .data(data), .data_ch(data_ch), .data_valid(data_valid),
        .csn(csn), .sclk(sclk), .sdi(sdi), .sdo(sdo), .fsm_state(fsm_state)
    );

    ads8684_spi_ctrl #(.CLK_DIV(1), .CS_GAP(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .channel(ch1), .auto_en(zero),
        .ready(ready1), .data(data1), .data_ch(data_ch1), .data_valid(dv1),
        .csn(csn1), .sclk(sclk1), .sdi(sdi1), .sdo(zero), .fsm_state(fsm_state1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- ADC model ----------------
    logic [15:0] ain [4];
    bit          adc_ok = 1'b0;
    logic [1:0]  adc_ch = 2'd0;
    logic [31:0] adc_word = 32'd0;
    logic [31:0] adc_rx = 32'd0;
    int          adc_bit = 0;
    int          adc_rises = 0;
    int          frames = 0;

    always @(negedge csn) begin
        adc_word  = {16'($urandom), adc_ok ? ain[adc_ch] : 16'hFFFF};
        adc_bit   = 31;
        sdo       = adc_word[31];
        adc_rises = 0;
        frames++;
    end

    always @(posedge sclk) if (!csn) begin
        adc_rx = {adc_rx[30:0], sdi};
        adc_rises++;
    end

    always @(negedge sclk) if (!csn && adc_bit > 0) begin
        adc_bit--;
        sdo = adc_word[adc_bit];
    end

    always @(posedge csn) begin
        adc_ok = (adc_rises == 32);
        adc_ch = adc_rx[27:26];
    end

    // ---------------- reference model ----------------
    int          m_t = -1;
    bit          m_rdy = 1'b0, m_prev = 1'b0, m_auto_q = 1'b0;
    bit          chk_en = 1'b0, e_dv = 1'b0, e_frame_end = 1'b0;
    logic [1:0]  m_cur_ch = 2'd0, m_prev_ch = 2'd0, m_scan = 2'd0, e_ch = 2'd0;
    logic [15:0] e_data = 16'd0;
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];

    always @(posedge clk) begin
        bit go;
        logic [1:0] gch;
        go = 1'b0;
        gch = channel;
        e_dv = 1'b0;
        e_frame_end = 1'b0;
        chk_en = 1'b1;
        if (!rst_n) begin
            m_t = -1; m_rdy = 1'b0; m_prev = 1'b0; m_auto_q = 1'b0;
            m_scan = 2'd0; m_cur_ch = 2'd0; m_prev_ch = 2'd0;
            e_ch = 2'd0; e_data = 16'd0;
            exp_q.delete();
        end else begin
`ifdef ADS8684_SPI_CTRL_AUTOSCAN_EN
            if (auto_en && !m_auto_q) m_scan = 2'd0;
            m_auto_q = auto_en;
`endif
            if (m_t >= 0) begin
                m_t++;
                if (m_t == SHIFT_LEN + 2) begin
                    e_frame_end = 1'b1;
                    if (m_prev) begin
                        e_dv = 1'b1;
                        e_ch = m_prev_ch;
                        e_data = ain[m_prev_ch];
                        exp_q.push_back({e_ch, e_data});
                    end
                    m_prev = 1'b1;
                    m_prev_ch = m_cur_ch;
                end
                if (m_t == LEN) m_t = -1;
            end else if (m_rdy) begin
`ifdef ADS8684_SPI_CTRL_AUTOSCAN_EN
                if (auto_en) begin
                    go = 1'b1;
                    gch = m_scan;
                    m_scan = m_scan + 2'd1;
                end else
`endif
                if (start) go = 1'b1;
                if (go) begin
                    m_t = 0;
                    m_cur_ch = gch;
                end
            end else begin
                m_rdy = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) if (chk_en) begin
        bit   busy;
        logic e_csn, e_sclk;
        busy   = (m_t >= 0);
        e_csn  = !(busy && m_t <= SHIFT_LEN + 1);
        e_sclk = (m_t >= 1 && m_t <= SHIFT_LEN) ? ((((m_t - 1) / D) % 2) == 1) : 1'b0;
        chk("ready", 32'(ready), 32'(!busy && m_rdy));
        chk("csn", 32'(csn), 32'(e_csn));
        chk("sclk", 32'(sclk), 32'(e_sclk));
        if (e_csn) chk("sdi_idle", 32'(sdi), 32'd0);
        chk("data_valid", 32'(data_valid), 32'(e_dv));
        chk("data_hold", 32'({data_ch, data}), 32'({e_ch, e_data}));
        if (data_valid && exp_q.size() > 0) chk("strobe", 32'({data_ch, data}), 32'(exp_q.pop_front()));
        if (data_valid) got_q.push_back({data_ch, data});
        if (e_frame_end) begin
            chk("sdi_word", adc_rx, {4'hC, m_cur_ch, 26'd0});
            chk("sclk_rises", 32'(adc_rises), 32'd32);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        auto_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_csn", 32'(csn), 32'd1);
        chk("rst_sclk_sdi", 32'({sclk, sdi}), 32'd0);
        chk("rst_data", 32'({data_ch, data}), 32'd0);
        chk("rst_dv", 32'(data_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", 32'(ready), 32'd1);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
    endtask

    task automatic start_frame(input logic [1:0] ch);
        wait_ready(LEN + 20);
        channel = ch;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        channel = 2'($urandom);
    endtask

    task automatic test_div1();
        int lo = 0, rises = 0, gap = 0, g = 0;
        logic ps = 1'b0;
        while (!ready1 && g < 50) begin @(negedge clk); g++; end
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        g = 0;
        while (!csn1 && g < 500) begin
            lo++;
            if (sclk1 && !ps) rises++;
            ps = sclk1;
            @(negedge clk);
            g++;
        end
        g = 0;
        while (!ready1 && g < 50) begin gap++; @(negedge clk); g++; end
        chk("div1_csn_low", 32'(lo), 32'd66);
        chk("div1_rises", 32'(rises), 32'd32);
        chk("div1_gap", 32'(gap), 32'd4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, g, f0;
        logic ps;
        logic [1:0] c1, c2;
        logic [17:0] scan_exp [5];
        scan_exp = '{{2'd0, 16'h1111}, {2'd1, 16'h2222}, {2'd2, 16'h3333},
                     {2'd3, 16'h4444}, {2'd0, 16'h1111}};
        for (int i = 0; i < 4; i++) ain[i] = 16'($urandom);

        do_reset();
        test_div1();

        // two ch0 frames: first yields nothing, second returns ain_0
        do_reset();
        ain[0] = 16'hCAFE;
        got_q.delete();
        start_frame(2'd0);
        wait_ready(LEN + 20);
        chk("f1_sdi_word", adc_rx, 32'hC0000000);
        chk("f1_no_strobe", 32'(got_q.size()), 32'd0);
        start_frame(2'd0);
        wait_ready(LEN + 20);
        chk("f2_strobes", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("f2_data", 32'(got_q[0]), 32'({2'd0, 16'hCAFE}));

        // random traffic, channel wiggled while busy
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 7) == 0);
            channel = 2'($urandom);
            if (m_t < 0 && $urandom_range(0, 3) == 0) ain[$urandom_range(0, 3)] = 16'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_ready(LEN + 20);

        // start held through a whole frame gives exactly one frame
        f0 = frames;
        channel = 2'd2;
        start = 1'b1;
        repeat (LEN) @(negedge clk);
        start = 1'b0;
        wait_ready(LEN + 20);
        chk("one_frame", 32'(frames - f0), 32'd1);

        // reset at the 10th sclk rise
        ain[0] = 16'h0A0A; ain[1] = 16'h1B1B; ain[2] = 16'h2C2C; ain[3] = 16'h3D3D;
        start_frame(2'd1);
        n = 0; g = 0; ps = sclk;
        while (n < 10 && g < 400) begin
            @(negedge clk);
            if (sclk && !ps) n++;
            ps = sclk;
            g++;
        end
        chk("rst_mid_rises", 32'(n), 32'd10);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_csn", 32'(csn), 32'd1);
        chk("rst_mid_sclk", 32'(sclk), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        got_q.delete();
        c1 = 2'($urandom);
        c2 = 2'($urandom);
        start_frame(c1);
        wait_ready(LEN + 20);
        chk("rst_next_no_strobe", 32'(got_q.size()), 32'd0);
        start_frame(c2);
        wait_ready(LEN + 20);
        chk("rst_second_strobes", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("rst_second_data", 32'(got_q[0]), 32'({c1, ain[c1]}));

`ifdef ADS8684_SPI_CTRL_AUTOSCAN_EN
        do_reset();
        ain[0] = 16'h1111; ain[1] = 16'h2222; ain[2] = 16'h3333; ain[3] = 16'h4444;
        got_q.delete();
        auto_en = 1'b1;
        n = 0;
        while (got_q.size() < 5 && n < 7 * LEN) begin
            start = 1'($urandom);
            channel = 2'($urandom);
            @(negedge clk);
            n++;
        end
        auto_en = 1'b0;
        start = 1'b0;
        wait_ready(LEN + 20);
        for (int i = 0; i < 5; i++)
            chk($sformatf("scan_%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'h3FFFF, 32'(scan_exp[i]));
`else
        auto_en = 1'b1;
        start = 1'b0;
        n = 0;
        repeat (1000) begin
            @(negedge clk);
            if (!csn) n++;
        end
        auto_en = 1'b0;
        chk("noscan_csn_low", 32'(n), 32'd0);
`endif

        repeat (5) @(negedge clk);
        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
